// File: rtl/mat_serialize.sv
// Matrix-to-scalar serializer: captures one packed MxN float matrix and
// streams its elements row-major over a scalar stb/ack port.
module mat_serialize #(
    parameter int M = 2,
    parameter int N = 3,
    localparam int RW = (M > 1) ? $clog2(M) : 1,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [M-1:0][N-1:0][31:0]    input_a,
    input  logic                         input_a_stb,
    output logic                         input_a_ack,
    output logic [31:0]                  output_z,
    output logic [RW-1:0]                output_z_row,
    output logic [CW-1:0]                output_z_col,
    output logic                         output_z_last,
    output logic                         output_z_stb,
    input  logic                         output_z_ack
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state_q, state_d;
    logic [M-1:0][N-1:0][31:0]   buf_q, buf_d;
    logic                        in_ack_q, in_ack_d;
    logic [31:0]                 z_q, z_d;
    logic [RW-1:0]               row_q, row_d;
    logic [CW-1:0]               col_q, col_d;
    logic                        last_q, last_d;
    logic                        stb_q, stb_d;

    int                          nr, nc;
    logic [31:0]                 nxt;

    always_comb begin
        nr = int'(row_q);
        nc = int'(col_q);
        if (nc == N - 1) begin
            nc = 0;
            nr = nr + 1;
        end else begin
            nc = nc + 1;
        end
        // Plain mux over all elements avoids out-of-range index widths.
        nxt = '0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                if (r == nr && c == nc) nxt = buf_q[r][c];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        in_ack_d = in_ack_q;
        z_d      = z_q;
        row_d    = row_q;
        col_d    = col_q;
        last_d   = last_q;
        stb_d    = stb_q;
        unique case (state_q)
            IDLE: begin
                in_ack_d = 1'b1;
                if (input_a_stb && in_ack_q) begin
                    buf_d    = input_a;
                    z_d      = input_a[0][0];
                    row_d    = '0;
                    col_d    = '0;
                    last_d   = (M * N == 1);
                    stb_d    = 1'b1;
                    in_ack_d = 1'b0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                in_ack_d = 1'b0;
                if (output_z_ack && stb_q) begin
                    if (last_q) begin
                        stb_d    = 1'b0;
                        last_d   = 1'b0;
                        in_ack_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        z_d    = nxt;
                        row_d  = RW'(nr);
                        col_d  = CW'(nc);
                        last_d = (nr == M - 1) && (nc == N - 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            in_ack_q <= 1'b0;
            z_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            last_q   <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            in_ack_q <= in_ack_d;
            z_q      <= z_d;
            row_q    <= row_d;
            col_q    <= col_d;
            last_q   <= last_d;
            stb_q    <= stb_d;
        end
    end

    assign input_a_ack   = in_ack_q;
    assign output_z      = z_q;
    assign output_z_row  = row_q;
    assign output_z_col  = col_q;
    assign output_z_last = last_q;
    assign output_z_stb  = stb_q;

endmodule
